mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between instruction fetch (IF)
//  and data load/store (DM) requesters.
//  - Latches the winning request and drives it onto the memory port until mem_ready.
//  - Returns a one-cycle ready pulse plus read data to the winner; exposes core_stall.
//  - Sits between the PC/instruction path, the ALU-addressed data path and a unified memory.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one variable-latency memory port between instruction fetch (IF) and data (DM).
// Latency : grant at the request edge; ready/rdata pulse one cycle after mem_ready; next grant two edges later.
// Backpress: requesters hold req until their ready pulse; DM bursts are capped while IF waits.
// Ports   : clock/reset_n; if_req/if_addr -> if_ready/if_rdata; dm_req/dm_we/dm_size/dm_addr/dm_wdata ->
//           dm_ready/dm_rdata; mem_req/mem_we/mem_size/mem_addr/mem_wdata <- mem_ready/mem_rdata;
//           core_stall (combinational), bus_error (one-cycle pulse on timeout abort).
module mem_port_arbiter #(
   parameter int MAX_DM_BURST   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [1:0]  dm_size,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ready,
   output logic [31:0] dm_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        core_stall,
   output logic        bus_error
);

   localparam int              BW         = $clog2(MAX_DM_BURST + 1);
   localparam logic [BW-1:0]   BURST_MAX  = BW'(MAX_DM_BURST);
   localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0]     WAIT_LAST  = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM, DONE} state_t;

   state_t        state, state_nxt;
   logic [31:0]   wait_cnt, wait_cnt_nxt;
   logic [BW-1:0] burst_cnt, burst_cnt_nxt;
   logic          mem_req_nxt, mem_we_nxt;
   logic [1:0]    mem_size_nxt;
   logic [31:0]   mem_addr_nxt, mem_wdata_nxt;
   logic          if_ready_nxt, dm_ready_nxt, bus_error_nxt;
   logic [31:0]   if_rdata_nxt, dm_rdata_nxt;
   logic          dm_win, timed_out;

   // DM keeps priority only while it has not exhausted its burst allowance against a waiting IF.
   assign dm_win     = dm_req && (!if_req || (burst_cnt < BURST_MAX));
   assign timed_out  = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
   assign core_stall = (if_req && !if_ready) || (dm_req && !dm_ready);

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      burst_cnt_nxt = burst_cnt;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_size_nxt  = mem_size;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      // Ready, rdata and bus_error are only ever non-zero during the DONE cycle.
      if_ready_nxt  = 1'b0;
      if_rdata_nxt  = 32'd0;
      dm_ready_nxt  = 1'b0;
      dm_rdata_nxt  = 32'd0;
      bus_error_nxt = 1'b0;

      case (state)
         IDLE: begin
            wait_cnt_nxt = 32'd0;
            if (!if_req) begin
               burst_cnt_nxt = '0;
            end
            if (dm_win) begin
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = dm_we;
               mem_size_nxt  = dm_size;
               mem_addr_nxt  = dm_addr;
               mem_wdata_nxt = dm_wdata;
               state_nxt     = WAIT_DM;
               if (if_req && (burst_cnt != BURST_MAX)) begin
                  burst_cnt_nxt = burst_cnt + BW'(1);
               end
            end else if (if_req) begin
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = 1'b0;
               mem_size_nxt  = 2'b10;
               mem_addr_nxt  = if_addr;
               mem_wdata_nxt = 32'd0;
               burst_cnt_nxt = '0;
               state_nxt     = WAIT_IF;
            end
         end
         WAIT_IF, WAIT_DM: begin
            if (mem_ready || timed_out) begin
               mem_req_nxt   = 1'b0;
               state_nxt     = DONE;
               bus_error_nxt = !mem_ready;
               if (state == WAIT_IF) begin
                  if_ready_nxt = 1'b1;
                  if_rdata_nxt = mem_ready ? mem_rdata : 32'd0;
               end else begin
                  dm_ready_nxt = 1'b1;
                  dm_rdata_nxt = (mem_ready && !mem_we) ? mem_rdata : 32'd0;
               end
            end else begin
               wait_cnt_nxt = wait_cnt + 32'd1;
            end
         end
         DONE: begin
            wait_cnt_nxt = 32'd0;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wait_cnt  <= 32'd0;
         burst_cnt <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_size  <= 2'b00;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         if_ready  <= 1'b0;
         if_rdata  <= 32'd0;
         dm_ready  <= 1'b0;
         dm_rdata  <= 32'd0;
         bus_error <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         burst_cnt <= burst_cnt_nxt;
         mem_req   <= mem_req_nxt;
         mem_we    <= mem_we_nxt;
         mem_size  <= mem_size_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         if_ready  <= if_ready_nxt;
         if_rdata  <= if_rdata_nxt;
         dm_ready  <= dm_ready_nxt;
         dm_rdata  <= dm_rdata_nxt;
         bus_error <= bus_error_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : randomized and directed bench for mem_port_arbiter against a transaction/timestamp model.
// Latency : model predicts grant edge, completion edge and the two-edge turnaround.
// Backpress: requesters hold their request until they see their ready pulse.
module tb_mem_port_arbiter;
   localparam int MAXB = 4;
   localparam int TO   = 8;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        if_req, if_ready;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_ready;
   logic [1:0]  dm_size;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_req, mem_we, mem_ready;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        core_stall, bus_error;

   mem_port_arbiter #(.MAX_DM_BURST(MAXB), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .core_stall(core_stall), .bus_error(bus_error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding access, tracked by the edge number at which it was
   // granted; the port becomes free for arbitration two edges after completion.
   int          cyc;
   bit          m_act, m_dm;
   int          m_start, m_free, m_burst;
   logic        e_mreq, e_we, e_ifr, e_dmr, e_berr;
   logic [1:0]  e_size;
   logic [31:0] e_addr, e_wdata, e_ifd, e_dmd;

   task automatic model_reset();
      m_act = 0; m_dm = 0; m_start = 0; m_free = 0; m_burst = 0;
      e_mreq = 0; e_we = 0; e_size = 0; e_addr = 0; e_wdata = 0;
      e_ifr = 0; e_dmr = 0; e_berr = 0; e_ifd = 0; e_dmd = 0;
   endtask

   task automatic model_edge();
      bit to;
      e_ifr = 0; e_dmr = 0; e_berr = 0; e_ifd = 0; e_dmd = 0;
      if (m_act) begin
         to = !mem_ready && (TO != 0) && (cyc - m_start == TO);
         if (mem_ready || to) begin
            m_act  = 0;
            e_mreq = 0;
            m_free = cyc + 2;
            e_berr = to;
            if (m_dm) begin
               e_dmr = 1;
               e_dmd = (to || e_we) ? 32'd0 : mem_rdata;
            end else begin
               e_ifr = 1;
               e_ifd = to ? 32'd0 : mem_rdata;
            end
         end
      end else if (cyc >= m_free) begin
         if (!if_req) m_burst = 0;
         if (dm_req && (!if_req || m_burst < MAXB)) begin
            m_act = 1; m_dm = 1; m_start = cyc; e_mreq = 1;
            e_we = dm_we; e_size = dm_size; e_addr = dm_addr; e_wdata = dm_wdata;
            if (if_req) m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
         end else if (if_req) begin
            m_act = 1; m_dm = 0; m_start = cyc; e_mreq = 1;
            e_we = 0; e_size = 2'b10; e_addr = if_addr; e_wdata = 0;
            m_burst = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("mem_req", 32'(mem_req), 32'(e_mreq));
      if (e_mreq) begin
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_size", 32'(mem_size), 32'(e_size));
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("if_ready", 32'(if_ready), 32'(e_ifr));
      chk("if_rdata", if_rdata, e_ifd);
      chk("dm_ready", 32'(dm_ready), 32'(e_dmr));
      chk("dm_rdata", dm_rdata, e_dmd);
      chk("bus_error", 32'(bus_error), 32'(e_berr));
      chk("core_stall", 32'(core_stall), 32'((if_req && !e_ifr) || (dm_req && !e_dmr)));
   endtask

   bit log_en = 0;
   bit obs_q[$];

   task automatic step();
      @(posedge clock);
      cyc++;
      model_edge();
      #1;
      compare_all();
      if (log_en) begin
         if (if_ready) obs_q.push_back(1'b1);
         if (dm_ready) obs_q.push_back(1'b0);
      end
      @(negedge clock);
   endtask

   int unsigned p_if, p_dm;
   int rmode;

   task automatic drive_random();
      if (if_req && if_ready) begin
         if ($urandom_range(99, 0) < p_if) if_addr = $urandom & 32'hFFFF_FFFC;
         else if_req = 1'b0;
      end else if (!if_req && ($urandom_range(99, 0) < p_if)) begin
         if_req  = 1'b1;
         if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if ((dm_req && dm_ready) || (!dm_req && ($urandom_range(99, 0) < p_dm))) begin
         dm_req = (!dm_req) || ($urandom_range(99, 0) < p_dm);
         dm_we    = ($urandom_range(1, 0) == 1);
         dm_size  = 2'($urandom_range(2, 0));
         dm_addr  = $urandom;
         dm_wdata = $urandom;
      end
      mem_rdata = $urandom;
      case (rmode)
         0:       mem_ready = ($urandom_range(2, 0) == 0);
         1:       mem_ready = 1'b1;
         default: mem_ready = 1'b0;
      endcase
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_size = 0;
      dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
   endtask

   initial begin
      int n_mreq, n_berr, n_dmr, long_runs;
      bit prev;
      logic [5:0] ord;

      reset_n = 1'b0;
      idle_inputs();
      model_reset();
      cyc = 0;
      #12;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_dm_ready", 32'(dm_ready), 32'd0);
      chk("rst_bus_error", 32'(bus_error), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) step();

      // Fetch with memory answering two cycles after the request appears.
      if_req = 1; if_addr = 32'h100;
      step();
      chk("t2_mem_we", 32'(mem_we), 32'd0);
      chk("t2_mem_size", 32'(mem_size), 32'd2);
      step();
      mem_ready = 1; mem_rdata = 32'h0050_0093;
      step();
      chk("t2_if_ready", 32'(if_ready), 32'd1);
      chk("t2_if_rdata", if_rdata, 32'h0050_0093);
      if_req = 0; mem_ready = 0;
      step();
      chk("t2_single_pulse", 32'(if_ready), 32'd0);
      step();

      // Half-word store: read data must come back as zero.
      dm_req = 1; dm_we = 1; dm_size = 2'b01; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF;
      step();
      chk("t4_mem_addr", mem_addr, 32'h2004);
      chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t4_mem_size", 32'(mem_size), 32'd1);
      chk("t4_mem_we", 32'(mem_we), 32'd1);
      mem_ready = 1; mem_rdata = 32'h1234_5678;
      step();
      chk("t4_dm_ready", 32'(dm_ready), 32'd1);
      chk("t4_dm_rdata", dm_rdata, 32'd0);
      dm_req = 0; mem_ready = 0;
      repeat (2) step();

      // Timeout: memory never answers.
      dm_req = 1; dm_we = 0; dm_size = 2'b10; dm_addr = 32'h3000;
      n_mreq = 0; n_berr = 0; n_dmr = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         n_mreq += int'(mem_req);
         n_berr += int'(bus_error);
         n_dmr  += int'(dm_ready);
         if (dm_ready) begin
            chk("t5_rdata", dm_rdata, 32'd0);
            dm_req = 0;
         end
      end
      chk("t5_mreq_cycles", 32'(n_mreq), 32'd8);
      chk("t5_berr_pulses", 32'(n_berr), 32'd1);
      chk("t5_ready_pulses", 32'(n_dmr), 32'd1);

      // Reset while a data access is in flight.
      dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
      repeat (3) step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t1_mem_req", 32'(mem_req), 32'd0);
      chk("t1_dm_ready", 32'(dm_ready), 32'd0);
      idle_inputs();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      n_dmr = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         n_dmr += int'(dm_ready) + int'(if_ready);
      end
      chk("t1_no_ready_after", 32'(n_dmr), 32'd0);

      // Both requesters saturated: DM x4, then one IF, then DM.
      p_if = 100; p_dm = 100; rmode = 0;
      obs_q.delete();
      log_en = 1;
      if_req = 1; if_addr = 32'h500;
      dm_req = 1; dm_we = 0; dm_size = 2'b10; dm_addr = 32'h6000;
      for (int i = 0; i < 400 && obs_q.size() < 6; i++) begin
         step();
         drive_random();
      end
      log_en = 0;
      chk("t3_enough_grants", 32'(obs_q.size() >= 6), 32'd1);
      ord = 6'd0;
      for (int i = 0; i < 6 && i < obs_q.size(); i++) ord[i] = obs_q[i];
      chk("t3_order", 32'(ord), 32'h10);

      // Random phases: mixed load, stuck-ready memory, and dead memory.
      p_if = 40; p_dm = 40; rmode = 0;
      repeat (600) begin step(); drive_random(); end
      p_if = 60; p_dm = 60; rmode = 1;
      prev = 0; long_runs = 0;
      repeat (300) begin
         step();
         if (mem_req && prev) long_runs++;
         prev = mem_req;
         drive_random();
      end
      chk("t6_mreq_single_cycle", 32'(long_runs), 32'd0);
      p_if = 50; p_dm = 50; rmode = 2;
      repeat (150) begin step(); drive_random(); end
      p_if = 20; p_dm = 70; rmode = 0;
      repeat (400) begin step(); drive_random(); end

      // Drain.
      p_if = 0; p_dm = 0; rmode = 0;
      repeat (40) begin step(); drive_random(); end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
